// File: rtl/activation_pipe.sv
// Pipelined activation unit: sigmoid / tanh / ReLU / identity per sample, 3-stage valid/ready pipe.
// Define ACTIVATION_INTERP_EN to interpolate linearly between adjacent sigmoid LUT entries.
module activation_pipe #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       FRAC_W     = 8,
  parameter int unsigned       LUT_ADDR_W = 6,
  parameter logic [DATA_W-1:0] SAT_LIMIT  = 16'h600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned LUT_DEPTH = 1 << LUT_ADDR_W;
  localparam int unsigned LUT_W     = FRAC_W + 1;
  localparam int unsigned S_W       = FRAC_W + 2;
  localparam int unsigned ABS_W     = DATA_W + 1;
  localparam int unsigned MAG_W     = DATA_W + 2;
`ifdef ACTIVATION_INTERP_EN
  localparam int unsigned FRAC_LO_W = FRAC_W + 3 - LUT_ADDR_W;
  localparam int unsigned PROD_W    = S_W + FRAC_LO_W + 1;
`endif
  localparam logic [S_W-1:0]    ONE_S = S_W'(1) << FRAC_W;
  localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1) << FRAC_W;

  typedef enum logic [1:0] {
    MODE_SIGMOID = 2'b00,
    MODE_TANH    = 2'b01,
    MODE_RELU    = 2'b10,
    MODE_IDENT   = 2'b11
  } mode_e;

  // round(2^FRAC_W * sigmoid(k*step)) via integer exp series (Q32), evaluated at elaboration
  function automatic int unsigned sigmoid_entry(input int unsigned k);
    longint unsigned term;
    longint unsigned e_pos;
    longint unsigned den;
    term  = 64'd1 << 32;
    e_pos = term;
    for (int n = 1; n < 48; n++) begin
      term  = (term * 64'(k)) / (64'(n) << (LUT_ADDR_W - 3));
      e_pos = e_pos + term;
    end
    den = e_pos + (64'd1 << 32);
    return 32'(((e_pos << (FRAC_W + 1)) + den) / (den << 1));
  endfunction

  logic [LUT_W-1:0] lut [LUT_DEPTH];
  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam logic [LUT_W-1:0] ENTRY = LUT_W'(sigmoid_entry(k));
    assign lut[k] = ENTRY;
  end

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  logic                  v1, v2;
  logic [DATA_W-1:0]     x1, x2;
  mode_e                 mode1, mode2;
  logic                  sign1, sign2, sat1, sat2;
  logic [LUT_ADDR_W-1:0] addr1;
  logic [LUT_W-1:0]      lut_a2;
`ifdef ACTIVATION_INTERP_EN
  logic [FRAC_LO_W-1:0]  frac1, frac2;
  logic [LUT_ADDR_W-1:0] addr_nx_c;
  logic [LUT_W-1:0]      lut_b2;
  assign addr_nx_c = (addr1 == '1) ? addr1 : addr1 + LUT_ADDR_W'(1);
`endif

  // Magnitude (doubled for tanh); widened so |most-negative| and doubling cannot wrap
  logic [ABS_W-1:0] abs_c;
  logic [MAG_W-1:0] mag_c;
  logic             sat_c;
  always_comb begin
    abs_c = in_data[DATA_W-1] ? ABS_W'(0) - {in_data[DATA_W-1], in_data} : {1'b0, in_data};
    mag_c = (mode_e'(in_mode) == MODE_TANH) ? {abs_c, 1'b0} : {1'b0, abs_c};
    sat_c = mag_c > MAG_W'(SAT_LIMIT);
  end

  logic [S_W-1:0]    s_c, s_eff_c;
  logic [DATA_W-1:0] sig_c, t_c, res_c;
`ifdef ACTIVATION_INTERP_EN
  logic signed [S_W-1:0]    diff_c;
  logic signed [PROD_W-1:0] prod_c;
`endif
  always_comb begin
`ifdef ACTIVATION_INTERP_EN
    diff_c = signed'({1'b0, lut_b2}) - signed'({1'b0, lut_a2});
    prod_c = PROD_W'(diff_c) * PROD_W'(signed'({1'b0, frac2}));
    s_c    = S_W'(lut_a2) + S_W'(prod_c >>> FRAC_LO_W);
`else
    s_c    = S_W'(lut_a2);
`endif
    s_eff_c = sat2 ? ONE_S : s_c;
    sig_c   = DATA_W'(s_eff_c);
    t_c     = (sig_c << 1) - ONE_D;
    res_c   = x2;
    case (mode2)
      MODE_SIGMOID: res_c = sign2 ? ONE_D - sig_c : sig_c;
      MODE_TANH:    res_c = sign2 ? DATA_W'(0) - t_c : t_c;
      MODE_RELU:    res_c = sign2 ? DATA_W'(0) : x2;
      default:      res_c = x2;
    endcase
  end

  // All three stages advance together; a stall freezes the whole pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      x1        <= '0;
      x2        <= '0;
      mode1     <= MODE_SIGMOID;
      mode2     <= MODE_SIGMOID;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      sat1      <= 1'b0;
      sat2      <= 1'b0;
      addr1     <= '0;
      lut_a2    <= '0;
`ifdef ACTIVATION_INTERP_EN
      frac1     <= '0;
      frac2     <= '0;
      lut_b2    <= '0;
`endif
    end else if (adv) begin
      v1        <= in_valid;
      x1        <= in_data;
      mode1     <= mode_e'(in_mode);
      sign1     <= in_data[DATA_W-1];
      sat1      <= sat_c;
      addr1     <= mag_c[FRAC_W+2 -: LUT_ADDR_W];
      v2        <= v1;
      x2        <= x1;
      mode2     <= mode1;
      sign2     <= sign1;
      sat2      <= sat1;
      lut_a2    <= lut[addr1];
`ifdef ACTIVATION_INTERP_EN
      frac1     <= mag_c[FRAC_LO_W-1:0];
      frac2     <= frac1;
      lut_b2    <= lut[addr_nx_c];
`endif
      out_valid <= v2;
      out_data  <= res_c;
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// Bench for activation_pipe: directed vectors with hand-computed results, latency, backpressure, mid-stream reset.
module tb_activation_pipe;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NVEC   = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0]        vec_m [NVEC];
  logic [DATA_W-1:0] vec_x [NVEC];
  logic [DATA_W-1:0] vec_e [NVEC];

  activation_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_vec(input int i, input logic [1:0] m, input logic [15:0] x, input logic [15:0] e);
    vec_m[i] = m;
    vec_x[i] = x;
    vec_e[i] = e;
  endtask

  task automatic load_vectors();
    set_vec(0,  2'b00, 16'h0000, 16'h0080);
    set_vec(1,  2'b00, 16'h0700, 16'h0100);
    set_vec(2,  2'b00, 16'hF900, 16'h0000);
    set_vec(3,  2'b00, 16'h0600, 16'h00FF);
    set_vec(4,  2'b01, 16'h0080, 16'h0076);
    set_vec(5,  2'b01, 16'hFF80, 16'hFF8A);
    set_vec(6,  2'b01, 16'h0400, 16'h0100);
    set_vec(7,  2'b01, 16'h8000, 16'hFF00);
    set_vec(8,  2'b10, 16'hFF00, 16'h0000);
    set_vec(9,  2'b10, 16'h0234, 16'h0234);
    set_vec(10, 2'b11, 16'hABCD, 16'hABCD);
`ifdef ACTIVATION_INTERP_EN
    set_vec(11, 2'b00, 16'h0010, 16'h0084);
`else
    set_vec(11, 2'b00, 16'h0010, 16'h0080);
`endif
    set_vec(12, 2'b00, 16'h0100, 16'h00BB);
    set_vec(13, 2'b00, 16'hFF00, 16'h0045);
    set_vec(14, 2'b00, 16'h0601, 16'h0100);
    set_vec(15, 2'b01, 16'hFF00, 16'hFF3E);
    set_vec(16, 2'b01, 16'h4000, 16'h0100);
    set_vec(17, 2'b11, 16'h8000, 16'h8000);
  endtask

  // Streams vectors [first, first+n) and checks every output in order
  task automatic run_stream(input int first, input int n, input bit rand_ready, input bit rand_gap);
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] hold_data;
    bit holding;
    bit accepted;
    int sent, got, cyc, stray;
    holding   = 1'b0;
    accepted  = 1'b0;
    hold_data = '0;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < n && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (accepted) in_valid = 1'b0;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!in_valid && sent < n && (!rand_gap || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = vec_x[first+sent];
        in_mode  = vec_m[first+sent];
      end
      #1;
      if (holding) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(hold_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("out_count", 32'(got + 1), 32'(sent));
        else check($sformatf("out[%0d]", first + got), 32'(out_data), 32'(exp_q.pop_front()));
        got++;
      end
      holding   = out_valid && !out_ready;
      hold_data = out_data;
      accepted  = in_valid && in_ready;
      if (accepted) begin
        exp_q.push_back(vec_e[first+sent]);
        sent++;
      end
    end
    check("stream_count", 32'(got), 32'(n));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (out_valid) stray++;
    end
    check("no_extra", 32'(stray), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timed out after %0d/%0d checks", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int stray;
    load_vectors();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single sample latency
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 16'h0000;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    check("lat_data", 32'(out_data), 32'h0080);
    @(posedge clk);
    #1;
    check("lat_drain", 32'(out_valid), 32'd0);

    run_stream(0, NVEC, 1'b0, 1'b0);
    run_stream(0, 16, 1'b1, 1'b1);

    // Fill and stall the pipe, then reset it mid-stream
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = vec_x[4];
    in_mode   = vec_m[4];
    repeat (5) @(negedge clk);
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid) stray++;
    end
    check("rst_stale", 32'(stray), 32'd0);
    run_stream(8, 4, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
